// File: rtl/popcount_window.sv
// Windowed popcount accumulator: counts set bits of each accepted sample, sums them over
// WINDOW samples, latches the window total and flags whether it reaches a threshold.
module popcount_window #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WINDOW = 8,
    localparam int unsigned CW = $clog2(WIDTH + 1),
    localparam int unsigned SW = $clog2(WIDTH * WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    input  logic [SW-1:0]    thr,
    output logic [WIDTH:0]   cnt_onehot,
    output logic [CW-1:0]    cnt_bin,
    output logic [SW-1:0]    sum,
    output logic [SW-1:0]    win_sum,
    output logic             done,
    output logic             above,
    output logic             busy
);

    localparam int unsigned OW = WIDTH + 1;
    localparam int unsigned IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic {StIdle, StAccum} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic [SW-1:0]  win_sum_q, win_sum_d;
    logic [CW-1:0]  cnt_bin_q, cnt_bin_d;
    logic [OW-1:0]  cnt_onehot_q, cnt_onehot_d;
    logic           done_q, done_d;
    logic           above_q, above_d;
    logic [CW-1:0]  pc;
    logic [SW-1:0]  acc_total;
    logic [1:0]     rst_sync_q;
    logic           rst_core_n;

    // Reset asserts asynchronously but releases only after two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_q[1];

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + CW'(in_data[i]);
        end
        acc_total = sum_q + SW'(pc);

        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        win_sum_d    = win_sum_q;
        cnt_bin_d    = cnt_bin_q;
        cnt_onehot_d = cnt_onehot_q;
        above_d      = above_q;
        done_d       = 1'b0;

        if (ena) begin
            if (clear) begin
                state_d = StIdle;
                idx_d   = '0;
                sum_d   = '0;
            end else if (in_valid) begin
                cnt_bin_d    = pc;
                cnt_onehot_d = OW'(1) << pc;
                if (idx_q == IW'(WINDOW - 1)) begin
                    win_sum_d = acc_total;
                    above_d   = (acc_total >= thr);
                    sum_d     = '0;
                    idx_d     = '0;
                    state_d   = StIdle;
                    done_d    = 1'b1;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    sum_d   = acc_total;
                    state_d = StAccum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            sum_q        <= '0;
            win_sum_q    <= '0;
            cnt_bin_q    <= '0;
            cnt_onehot_q <= OW'(1);
            done_q       <= 1'b0;
            above_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            win_sum_q    <= win_sum_d;
            cnt_bin_q    <= cnt_bin_d;
            cnt_onehot_q <= cnt_onehot_d;
            done_q       <= done_d;
            above_q      <= above_d;
        end
    end

    assign cnt_onehot = cnt_onehot_q;
    assign cnt_bin    = cnt_bin_q;
    assign sum        = sum_q;
    assign win_sum    = win_sum_q;
    assign done       = done_q;
    assign above      = above_q;
    assign busy       = (state_q == StAccum);

endmodule

// File: tb/tb_popcount_window.sv
// Bench for popcount_window: queue-based window model, per-cycle checks and a
// scoreboard of completed windows popped by a monitor on each done pulse.
module tb_popcount_window;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [3:0] in_data;
    logic       clear;
    logic [5:0] thr;
    logic [4:0] cnt_onehot;
    logic [2:0] cnt_bin;
    logic [5:0] sum;
    logic [5:0] win_sum;
    logic       done;
    logic       above;
    logic       busy;

    popcount_window #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clear      (clear),
        .thr        (thr),
        .cnt_onehot (cnt_onehot),
        .cnt_bin    (cnt_bin),
        .sum        (sum),
        .win_sum    (win_sum),
        .done       (done),
        .above      (above),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tot;
        bit ab;
    } win_t;

    win_t sbq[$];
    int   mq[$];
    int   exp_cnt;
    int   exp_win;
    bit   exp_above;
    bit   exp_done;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int model_sum();
        int s = 0;
        foreach (mq[i]) s += mq[i];
        return s;
    endfunction

    function automatic void model_reset();
        mq.delete();
        exp_cnt   = 0;
        exp_win   = 0;
        exp_above = 0;
        exp_done  = 0;
    endfunction

    task automatic check_all();
        chk("sum", int'(sum), model_sum());
        chk("busy", int'(busy), (mq.size() > 0) ? 1 : 0);
        chk("done", int'(done), int'(exp_done));
        chk("cnt_bin", int'(cnt_bin), exp_cnt);
        chk("cnt_onehot", int'(cnt_onehot), 1 << exp_cnt);
        chk("win_sum", int'(win_sum), exp_win);
        chk("above", int'(above), int'(exp_above));
    endtask

    task automatic step(input bit e, input bit v, input bit c, input logic [3:0] d,
                        input int t);
        int   pc;
        win_t w;
        ena      = e;
        in_valid = v;
        clear    = c;
        in_data  = d;
        thr      = 6'(t);
        @(posedge clk);
        exp_done = 0;
        if (e) begin
            if (c) begin
                mq.delete();
            end else if (v) begin
                pc      = $countones(d);
                exp_cnt = pc;
                mq.push_back(pc);
                if (mq.size() == WINDOW) begin
                    w.tot     = model_sum();
                    w.ab      = (w.tot >= t);
                    exp_win   = w.tot;
                    exp_above = w.ab;
                    exp_done  = 1;
                    sbq.push_back(w);
                    mq.delete();
                end
            end
        end
        #1;
        check_all();
    endtask

    // Monitor: each done pulse must match the oldest completed window in the model.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1 expected no pending window");
            end else begin
                win_t w;
                w = sbq.pop_front();
                chk("sb_win_sum", int'(win_sum), w.tot);
                chk("sb_above", int'(above), int'(w.ab));
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_cnt_onehot", int'(cnt_onehot), 1);
        chk("rst_cnt_bin", int'(cnt_bin), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_win_sum", int'(win_sum), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_above", int'(above), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = '0;
        thr      = 6'd16;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1, 0, 0, 4'b0000, 16);

        // Single accept of 1011
        step(1, 1, 0, 4'b1011, 16);
        chk("single_cnt_bin", int'(cnt_bin), 3);
        chk("single_onehot", int'(cnt_onehot), 5'b01000);

        // Mid-window asynchronous reset
        step(1, 1, 0, 4'b0111, 16);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        ena      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1, 0, 0, 4'b0000, 16);

        // Full window of 1111, then an accept while done is high
        repeat (8) step(1, 1, 0, 4'b1111, 16);
        chk("full_win_sum", int'(win_sum), 32);
        chk("full_done", int'(done), 1);
        step(1, 1, 0, 4'b1111, 16);
        chk("b2b_sum", int'(sum), 4);
        repeat (7) step(1, 0, 0, 4'b0000, 16);
        repeat (7) step(1, 1, 0, 4'b0000, 16);

        // Window of 0001 stays below threshold
        repeat (8) step(1, 1, 0, 4'b0001, 16);
        chk("low_above", int'(above), 0);

        // Clear with in_valid discards the sample, then exact threshold window
        repeat (3) step(1, 1, 0, 4'b1111, 16);
        step(1, 1, 1, 4'b1111, 16);
        chk("clear_cnt_bin_held", int'(cnt_bin), 4);
        repeat (8) step(1, 1, 0, 4'b0011, 16);
        chk("eq_thr_above", int'(above), 1);

        // ena low freezes state; done present when ena falls still clears
        repeat (7) step(1, 1, 0, 4'b0101, 16);
        step(1, 1, 0, 4'b0101, 16);
        repeat (5) step(0, 1, 0, 4'b1111, 16);
        step(0, 1, 1, 4'b1111, 16);
        repeat (3) step(1, 1, 0, 4'b0110, 16);
        repeat (5) step(0, 1, 0, 4'b1111, 16);
        step(0, 0, 1, 4'b0000, 16);

        // thr only matters at completion
        repeat (5) step(1, 1, 0, 4'b1110, 0);
        step(1, 1, 0, 4'b1110, 40);

        repeat (400) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, 4'($urandom), int'($urandom_range(0, 32)));
        end

        repeat (3) step(1, 0, 0, 4'b0000, 16);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
